// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// rob_pkg : shared sizes, types and helpers for the reorder buffer | Rev 1.0
// ============================================================================
package rob_pkg;

  localparam int ROB_SIZE = 32;
  localparam int PR_W     = 7;
  localparam int AR_W     = 5;
  localparam int IDX_W    = $clog2(ROB_SIZE);
  localparam int CNT_W    = IDX_W + 1;

  typedef logic [PR_W-1:0]  pr_t;
  typedef logic [AR_W-1:0]  ar_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam pr_t ZERO_TAG = '0;

  typedef struct packed {
    ar_t ar;
    pr_t new_pr;
    pr_t old_pr;
  } rob_fields_t;

  // Free slots saturate at the dispatch width of two.
  function automatic logic [1:0] free_slots(input cnt_t count);
    logic [1:0] slots;
    slots = 2'd2;
    if (count == cnt_t'(ROB_SIZE))
      slots = 2'd0;
    else if (count == cnt_t'(ROB_SIZE - 1))
      slots = 2'd1;
    return slots;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_if.sv
`default_nettype none
// ============================================================================
// rob_if : dispatch / CDB / retire bundle of the reorder buffer | Rev 1.0
// ============================================================================
interface rob_if;
  import rob_pkg::*;

  logic [1:0] id_dispatch_num;
  ar_t        id_dest_ar0, id_dest_ar1;
  pr_t        fl_pr0, fl_pr1;
  pr_t        mt_old_pr0, mt_old_pr1;
  logic       cdb_valid0, cdb_valid1;
  pr_t        cdb_tag0, cdb_tag1;
  logic       cdb_mispred0, cdb_mispred1;

  logic [1:0] rob_retire_num;
  pr_t        rob_retire_tag_0, rob_retire_tag_1;
  ar_t        rob_retire_ar0, rob_retire_ar1;
  pr_t        rob_retire_pr0, rob_retire_pr1;
  logic [1:0] rob_free_slots;
  logic       rob_empty;
  logic       rob_flush;

  modport master (
    output id_dispatch_num, id_dest_ar0, id_dest_ar1, fl_pr0, fl_pr1,
           mt_old_pr0, mt_old_pr1, cdb_valid0, cdb_valid1, cdb_tag0, cdb_tag1,
           cdb_mispred0, cdb_mispred1,
    input  rob_retire_num, rob_retire_tag_0, rob_retire_tag_1, rob_retire_ar0,
           rob_retire_ar1, rob_retire_pr0, rob_retire_pr1, rob_free_slots,
           rob_empty, rob_flush
  );

  modport slave (
    input  id_dispatch_num, id_dest_ar0, id_dest_ar1, fl_pr0, fl_pr1,
           mt_old_pr0, mt_old_pr1, cdb_valid0, cdb_valid1, cdb_tag0, cdb_tag1,
           cdb_mispred0, cdb_mispred1,
    output rob_retire_num, rob_retire_tag_0, rob_retire_tag_1, rob_retire_ar0,
           rob_retire_ar1, rob_retire_pr0, rob_retire_pr1, rob_free_slots,
           rob_empty, rob_flush
  );

endinterface
`default_nettype wire

// File: rtl/rob_entry.sv
`default_nettype none
// ============================================================================
// rob_entry : one ROB slot with dual-port CDB tag match and flush clear | Rev 1.0
// ============================================================================
module rob_entry
  import rob_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 we_i,
  input  logic                 clr_i,
  input  rob_fields_t          wdata_i,
  input  logic [1:0]           cdb_valid_i,
  input  logic [1:0][PR_W-1:0] cdb_tag_i,
  input  logic [1:0]           cdb_mispred_i,
  output logic                 valid_o,
  output logic                 done_o,
  output logic                 mispred_o,
  output rob_fields_t          fields_o
);

  logic        valid_q, done_q, mispred_q;
  rob_fields_t fields_q;
  logic        w_hit, w_mis_hit;

  always_comb begin
    w_hit     = 1'b0;
    w_mis_hit = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (cdb_valid_i[p] && valid_q && (cdb_tag_i[p] == fields_q.new_pr)) begin
        w_hit = 1'b1;
        if (cdb_mispred_i[p])
          w_mis_hit = 1'b1;
      end
    end
  end

  // Flush beats a fresh write; a fresh write beats a stale CDB match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      mispred_q <= 1'b0;
      fields_q  <= '0;
    end else if (flush_i) begin
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      mispred_q <= 1'b0;
    end else if (we_i) begin
      valid_q   <= 1'b1;
      done_q    <= 1'b0;
      mispred_q <= 1'b0;
      fields_q  <= wdata_i;
    end else if (clr_i) begin
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      mispred_q <= 1'b0;
    end else if (w_hit) begin
      done_q <= 1'b1;
      if (w_mis_hit)
        mispred_q <= 1'b1;
    end
  end

  assign valid_o   = valid_q;
  assign done_o    = done_q;
  assign mispred_o = mispred_q;
  assign fields_o  = fields_q;

endmodule
`default_nettype wire

// File: rtl/rob.sv
`default_nettype none
// ============================================================================
// rob : 2-wide circular reorder buffer, in-order retire with mispredict flush | Rev 1.0
// ============================================================================
module rob
  import rob_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  rob_if.slave bus_io
);

  idx_t head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d;

  logic [ROB_SIZE-1:0] valid_w, done_w, mispred_w, we_w, clr_w;
  rob_fields_t         fields_w [ROB_SIZE];
  rob_fields_t         w_wdata0, w_wdata1;
  logic [1:0]          w_free, w_accept, w_retire;
  idx_t                w_head1, w_tail1;
  logic                w_e0_done, w_e1_done, w_flush;
  logic [1:0]          w_cdb_valid, w_cdb_mispred;
  logic [1:0][PR_W-1:0] w_cdb_tag;

  assign w_head1 = head_q + idx_t'(1);
  assign w_tail1 = tail_q + idx_t'(1);

  assign w_e0_done = valid_w[head_q]  & done_w[head_q];
  assign w_e1_done = valid_w[w_head1] & done_w[w_head1];
  assign w_flush   = w_e0_done & mispred_w[head_q];

  // A mispredicted head retires alone so nothing younger escapes the flush.
  always_comb begin
    w_retire = 2'd0;
    if (w_e0_done) begin
      if (mispred_w[head_q] || !w_e1_done)
        w_retire = 2'd1;
      else
        w_retire = 2'd2;
    end
  end

  assign w_free = free_slots(count_q);

  always_comb begin
    w_accept = (bus_io.id_dispatch_num > w_free) ? w_free : bus_io.id_dispatch_num;
    if (w_flush)
      w_accept = 2'd0;
  end

  always_comb begin
    we_w  = '0;
    clr_w = '0;
    if (w_accept != 2'd0) we_w[tail_q]   = 1'b1;
    if (w_accept == 2'd2) we_w[w_tail1]  = 1'b1;
    if (w_retire != 2'd0) clr_w[head_q]  = 1'b1;
    if (w_retire == 2'd2) clr_w[w_head1] = 1'b1;
  end

  assign w_wdata0      = '{ar: bus_io.id_dest_ar0, new_pr: bus_io.fl_pr0, old_pr: bus_io.mt_old_pr0};
  assign w_wdata1      = '{ar: bus_io.id_dest_ar1, new_pr: bus_io.fl_pr1, old_pr: bus_io.mt_old_pr1};
  assign w_cdb_valid   = {bus_io.cdb_valid1, bus_io.cdb_valid0};
  assign w_cdb_tag     = {bus_io.cdb_tag1, bus_io.cdb_tag0};
  assign w_cdb_mispred = {bus_io.cdb_mispred1, bus_io.cdb_mispred0};

  for (genvar g = 0; g < ROB_SIZE; g++) begin : g_entry
    rob_entry u_entry (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (w_flush),
      .we_i          (we_w[g]),
      .clr_i         (clr_w[g]),
      .wdata_i       ((idx_t'(g) == tail_q) ? w_wdata0 : w_wdata1),
      .cdb_valid_i   (w_cdb_valid),
      .cdb_tag_i     (w_cdb_tag),
      .cdb_mispred_i (w_cdb_mispred),
      .valid_o       (valid_w[g]),
      .done_o        (done_w[g]),
      .mispred_o     (mispred_w[g]),
      .fields_o      (fields_w[g])
    );
  end

  always_comb begin
    head_d  = head_q + idx_t'(w_retire);
    tail_d  = tail_q + idx_t'(w_accept);
    count_d = count_q + cnt_t'(w_accept) - cnt_t'(w_retire);
    if (w_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    bus_io.rob_retire_tag_0 = ZERO_TAG;
    bus_io.rob_retire_tag_1 = ZERO_TAG;
    bus_io.rob_retire_ar0   = '0;
    bus_io.rob_retire_ar1   = '0;
    bus_io.rob_retire_pr0   = ZERO_TAG;
    bus_io.rob_retire_pr1   = ZERO_TAG;
    if (w_retire != 2'd0) begin
      bus_io.rob_retire_tag_0 = fields_w[head_q].old_pr;
      bus_io.rob_retire_ar0   = fields_w[head_q].ar;
      bus_io.rob_retire_pr0   = fields_w[head_q].new_pr;
    end
    if (w_retire == 2'd2) begin
      bus_io.rob_retire_tag_1 = fields_w[w_head1].old_pr;
      bus_io.rob_retire_ar1   = fields_w[w_head1].ar;
      bus_io.rob_retire_pr1   = fields_w[w_head1].new_pr;
    end
  end

  assign bus_io.rob_retire_num = w_retire;
  assign bus_io.rob_free_slots = w_free;
  assign bus_io.rob_empty      = (count_q == '0);
  assign bus_io.rob_flush      = w_flush;

endmodule
`default_nettype wire

// File: doc/rob.md
# rob

2-wide circular reorder buffer for the R10K-style out-of-order core. Sits directly upstream of the free list: takes new physical tags from the free list and old mappings from the map table at dispatch, marks entries complete from CDB broadcasts, and retires in order, returning each retiring instruction's old physical tag so the free list can reclaim it. Also raises a pipeline flush when a mispredicted branch reaches the head.

## Interface
- ROB_SIZE, 32, entries; power of two.
- PR_W, 7, physical tag width.
- AR_W, 5, architectural register width.
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; asserted when 0.
- id_dispatch_num  input  2  instructions dispatched this cycle, 0..2.
- id_dest_ar0, id_dest_ar1  input  AR_W  destination architectural registers.
- fl_pr0, fl_pr1  input  PR_W  new physical tags from the free list.
- mt_old_pr0, mt_old_pr1  input  PR_W  previous mappings from the map table.
- cdb_valid0, cdb_valid1  input  1  completion broadcast valid.
- cdb_tag0, cdb_tag1  input  PR_W  completing physical tag.
- cdb_mispred0, cdb_mispred1  input  1  completing instruction is a mispredicted branch.
- rob_retire_num  output  2  instructions retiring this cycle, 0..2.
- rob_retire_tag_0, rob_retire_tag_1  output  PR_W  old physical tags freed, to the free list.
- rob_retire_ar0, rob_retire_ar1  output  AR_W  retiring architectural destinations.
- rob_retire_pr0, rob_retire_pr1  output  PR_W  retiring new tags, to the architectural map.
- rob_free_slots  output  2  min(free entries, 2).
- rob_empty  output  1  count == 0.
- rob_flush  output  1  mispredict at the head is retiring this cycle.

## Operation
- Per-entry state: valid, done, mispred, ar, new_pr, old_pr. Global state: head and tail (log2(ROB_SIZE) bits, modulo wrap) and count (0..ROB_SIZE).
- Dispatch: accepted = min(id_dispatch_num, rob_free_slots). Excess dispatch requests are dropped. Slot 0 is written at tail, slot 1 at tail+1. Written entries have done=0 and mispred=0. tail advances by the accepted count.
- Completion: each valid CDB tag is compared against the new_pr of every valid entry. A match sets done, and sets mispred if the corresponding mispred bit is high. Both CDB ports may complete in the same cycle.
- Retire (combinational from registered state):
  - Entry0 = head, entry1 = head+1.
  - Retire 0 if entry0 is not valid and done.
  - Retire 1 if entry0 is done and either entry0.mispred is set or entry1 is not done.
  - Retire 2 otherwise.
  - Outputs for non-retiring slots are driven to 0.
- Flush: rob_flush = entry0 retiring with mispred set. At the next edge all valid bits clear and head = tail = count = 0. Dispatch and CDB inputs in the flush cycle are ignored.
- count_next = count + accepted − rob_retire_num (no flush).
- rob_free_slots is computed from the registered count. Entries freed by a same-cycle retire are not reusable until the next cycle.

## Timing
- Reset values: head = tail = count = 0, all entry valid = 0, rob_retire_num = 0, all retire tags/ar/pr = 0, rob_free_slots = 2, rob_empty = 1, rob_flush = 0.
- Dispatch at edge t makes the entry visible at t+1.
- A CDB completion at cycle t makes the entry eligible to retire at cycle t+1. There is no same-cycle CDB-to-retire bypass.
- Retire outputs are valid in the same cycle the head state is done. head advances at the next edge.
- Full (count = ROB_SIZE): free_slots = 0. count = ROB_SIZE−1: free_slots = 1.
- Wrap: head and tail roll from ROB_SIZE−1 to 0. A 2-wide dispatch or retire straddling the wrap uses indices ROB_SIZE−1 and 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Structure
- Shared header sys_defs.vh holds ROB_SIZE, PR_W, AR_W, and a zero-tag constant; the free list and map table use the same defines.
- One sub-module, rob_entry: holds a single entry's fields, performs the dual-port CDB match, and handles write-enable and flush-clear. It is instantiated ROB_SIZE times.
- The top level contains the pointers, count, dispatch and retire selection, and the output muxing.

## Test plan
- Reset → rob_empty = 1, free_slots = 2, retire_num = 0, all outputs 0. Releasing reset mid-stream leaves state cleared.
- 16 cycles of 2-wide dispatch (tags 32..63) → count = 32, free_slots = 0. A further dispatch of 2 is dropped and tail stays unchanged.
- Dispatch A (pr 40, old 5) and B (pr 41, old 6); complete B first, then A → no retire until A is done. The cycle after A's CDB: retire_num = 2, tags 5 and 6.
- Head at 31: dispatch 2 then complete and retire both → entries 31 and 0 are used, head ends at 1, count = 0.
- Head A done with mispred = 1 and head+1 done → retire_num = 1, rob_flush = 1. The next cycle is empty with head = tail = 0. A dispatch in the flush cycle is discarded.
- count = 31 with the head done: dispatch 2 and retire 1 in the same cycle → only 1 dispatch is accepted and count stays 31.
